// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Two-master bus arbiter with serial slave selection. A granted master shifts
// its slave index in MSB first over SLAVE_LEN cycles, then owns the bus until
// it pulses trans_done or drops its request. Ties are broken round-robin
// against the master granted last. Every output is registered.
//
// Optional feature: define ARB_TIMEOUT_EN to enable a BUSY watchdog that
// releases the bus after TIMEOUT_CYCLES cycles without trans_done and pulses
// timeout for the single RELEASE cycle. Without the macro, timeout is tied 0.
//
// Parameters:
//   SLAVE_LEN       width of the serial slave index (2**SLAVE_LEN slaves)
//   TIMEOUT_CYCLES  BUSY cycles allowed before the watchdog fires
//
// Ports:
//   clk                  system clock, rising edge
//   reset                asynchronous, active-high reset
//   m1_request/m2_request       bus requests from master 1/2
//   m1_slave_select/m2_slave_select  serial slave index bits, MSB first
//   trans_done           end-of-transaction pulse from the granted master
//   m1_grant/m2_grant    bus grant to master 1/2 (mutually exclusive)
//   arbitor_busy         a grant is active (SSEL or BUSY)
//   bus_busy             address/data phase in progress (BUSY)
//   mux_sel              bus mux select: 0 = master 1, 1 = master 2
//   slave_sel            last fully captured slave index
//   slave_en             one-hot slave enable, active only in BUSY
//   timeout              one-cycle watchdog release pulse
// -----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int SLAVE_LEN      = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      m1_request,
    input  logic                      m2_request,
    input  logic                      m1_slave_select,
    input  logic                      m2_slave_select,
    input  logic                      trans_done,
    output logic                      m1_grant,
    output logic                      m2_grant,
    output logic                      arbitor_busy,
    output logic                      bus_busy,
    output logic                      mux_sel,
    output logic [SLAVE_LEN-1:0]      slave_sel,
    output logic [2**SLAVE_LEN-1:0]   slave_en,
    output logic                      timeout
);

    localparam int NUM_SLAVES = 2**SLAVE_LEN;
    localparam int BIT_CNT_W  = $clog2(SLAVE_LEN) + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SSEL    = 2'd1,
        BUSY    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    last_q, last_d;        // 0 = master 1 granted last
    logic [SLAVE_LEN-1:0]    shift_q, shift_d;      // partial index during SSEL
    logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                    mux_sel_q, mux_sel_d;  // doubles as current owner
    logic [SLAVE_LEN-1:0]    slave_sel_q, slave_sel_d;
    logic [NUM_SLAVES-1:0]   slave_en_q, slave_en_d;
    logic                    m1_grant_q, m1_grant_d;
    logic                    m2_grant_q, m2_grant_d;
    logic                    arb_busy_q, arb_busy_d;
    logic                    bus_busy_q, bus_busy_d;

`ifdef ARB_TIMEOUT_EN
    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDOG_W-1:0]       wdog_q, wdog_d;
    logic                    timeout_q, timeout_d;
`endif

    logic                    owner_req;
    logic                    owner_bit;
    logic                    active_d;

    // The owner's request and serial bit; only meaningful in SSEL/BUSY.
    assign owner_req = mux_sel_q ? m2_request      : m1_request;
    assign owner_bit = mux_sel_q ? m2_slave_select : m1_slave_select;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; an unassigned path would infer a latch.
        state_d     = state_q;
        last_d      = last_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        mux_sel_d   = mux_sel_q;
        slave_sel_d = slave_sel_q;
`ifdef ARB_TIMEOUT_EN
        wdog_d      = wdog_q;
        timeout_d   = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (m1_request || m2_request) begin
                    state_d   = SSEL;
                    shift_d   = '0;
                    bit_cnt_d = '0;
                    // Tie goes to whichever master was not granted last.
                    if (m1_request && m2_request) mux_sel_d = ~last_q;
                    else                          mux_sel_d = m2_request;
                end
            end

            SSEL: begin
                if (!owner_req) begin
                    // Abort: the partial index never reaches slave_sel.
                    state_d = RELEASE;
                    last_d  = mux_sel_q;
                end else begin
                    shift_d    = shift_q << 1;
                    shift_d[0] = owner_bit;
                    bit_cnt_d  = bit_cnt_q + BIT_CNT_W'(1);
                    if (bit_cnt_q == BIT_CNT_W'(SLAVE_LEN - 1)) begin
                        state_d     = BUSY;
                        slave_sel_d = shift_d;
`ifdef ARB_TIMEOUT_EN
                        wdog_d      = '0;
`endif
                    end
                end
            end

            BUSY: begin
                // trans_done wins over a simultaneous request drop; both end
                // the transaction the same way.
                if (trans_done || !owner_req) begin
                    state_d = RELEASE;
                    last_d  = mux_sel_q;
`ifdef ARB_TIMEOUT_EN
                end else if (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = RELEASE;
                    last_d    = mux_sel_q;
                    timeout_d = 1'b1;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
`endif
                end
            end

            RELEASE: state_d = IDLE;

            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they register in step
        // with the state they describe.
        active_d   = (state_d == SSEL) || (state_d == BUSY);
        m1_grant_d = active_d && !mux_sel_d;
        m2_grant_d = active_d &&  mux_sel_d;
        arb_busy_d = active_d;
        bus_busy_d = (state_d == BUSY);
        slave_en_d = '0;
        if (state_d == BUSY) slave_en_d[slave_sel_d] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;    // master 2 "last" so master 1 wins first tie
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            mux_sel_q   <= 1'b0;
            slave_sel_q <= '0;
            slave_en_q  <= '0;
            m1_grant_q  <= 1'b0;
            m2_grant_q  <= 1'b0;
            arb_busy_q  <= 1'b0;
            bus_busy_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            mux_sel_q   <= mux_sel_d;
            slave_sel_q <= slave_sel_d;
            slave_en_q  <= slave_en_d;
            m1_grant_q  <= m1_grant_d;
            m2_grant_q  <= m2_grant_d;
            arb_busy_q  <= arb_busy_d;
            bus_busy_q  <= bus_busy_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign m1_grant     = m1_grant_q;
    assign m2_grant     = m2_grant_q;
    assign arbitor_busy = arb_busy_q;
    assign bus_busy     = bus_busy_q;
    assign mux_sel      = mux_sel_q;
    assign slave_sel    = slave_sel_q;
    assign slave_en     = slave_en_q;

endmodule
